pulse_stretcher: RTL and testbench

Consumer-side companion to the push-button one-pulser. Takes single-cycle enable pulses (`pulse_in`) and turns each into a fixed-width high pulse on `stretch_out`, followed by a mandatory low gap. Pulses arriving while an output pulse is in progress are counted and replayed, so no button press is lost until the pending counter saturates. Sits between the one-pulser and slow consumers (LED strobes, modulator step/trigger inputs) that need a minimum high time and a minimum low time.

---
 rtl/pulse_stretcher.sv | 103 ++++++++++
 tb/tb_pulse_stretcher.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into HIGH_LEN-cycle pulses separated by LOW_LEN-cycle gaps.
// Requests that arrive while a pulse or gap is running are queued in a saturating counter.
module pulse_stretcher #(
  parameter int HIGH_LEN = 16,
  parameter int LOW_LEN  = 4,
  parameter int CNT_W    = 8,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              stretch_out,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [CNT_W-1:0]  HIGH_INIT = CNT_W'(HIGH_LEN - 1);
  localparam logic [CNT_W-1:0]  LOW_INIT  = CNT_W'(LOW_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             gap_exit;
  logic             queue_inc;
  logic             queue_dec;

  // At gap exit with an empty queue a new request starts HIGH directly instead of queuing.
  assign gap_exit  = (state == GAP) && (cnt == '0);
  assign queue_dec = gap_exit && (pending != '0);
  assign queue_inc = pulse_in && (state != IDLE) && !(gap_exit && (pending == '0));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_n = HIGH;
          cnt_n   = HIGH_INIT;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = LOW_INIT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if ((pending != '0) || pulse_in) begin
            state_n = HIGH;
            cnt_n   = HIGH_INIT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stretch_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pending     <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      stretch_out <= (state_n == HIGH);
      busy        <= (state_n != IDLE);
      done        <= (state == HIGH) && (cnt == '0);
      if (queue_inc && !queue_dec) begin
        if (pending == PEND_MAX) begin
          overflow <= 1'b1;
        end else begin
          pending <= pending + PEND_W'(1);
        end
      end else if (queue_dec && !queue_inc) begin
        pending <= pending - PEND_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized and directed bench for pulse_stretcher, compared every cycle against a
// timeline model that tracks elapsed cycles since each pulse started.
module tb_pulse_stretcher;

  localparam int HIGH_LEN = 16;
  localparam int LOW_LEN  = 4;
  localparam int PEND_W   = 3;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              pulse_in;
  logic              stretch_out;
  logic              busy;
  logic              done;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int rises    = 0;
  int dones    = 0;
  logic prev_stretch = 1'b0;

  // Model: a pulse is "active" from its start edge; age counts edges since then.
  bit m_active = 1'b0;
  int m_age    = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;

  pulse_stretcher #(
    .HIGH_LEN(HIGH_LEN),
    .LOW_LEN (LOW_LEN),
    .CNT_W   (8),
    .PEND_W  (PEND_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .stretch_out(stretch_out),
    .busy       (busy),
    .done       (done),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, obs, exp);
    end
  endtask

  task automatic modelStep(input bit p, input bit r);
    if (r) begin
      m_active = 1'b0;
      m_age    = 0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else if (!m_active) begin
      if (p) begin
        m_active = 1'b1;
        m_age    = 0;
      end
    end else if (m_age == HIGH_LEN + LOW_LEN - 1) begin
      if (m_pend > 0) begin
        m_age = 0;
        if (!p) m_pend--;
      end else if (p) begin
        m_age = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_age++;
      if (p) begin
        if (m_pend == PEND_MAX) m_ovf = 1'b1;
        else m_pend++;
      end
    end
  endtask

  task automatic applyStimulus(input bit p, input bit r);
    pulse_in = p;
    rst      = r;
    @(posedge clk);
    modelStep(p, r);
    cycle++;
    @(negedge clk);
    checkOutput("stretch_out", 32'(stretch_out), 32'(m_active && (m_age < HIGH_LEN)));
    checkOutput("busy", 32'(busy), 32'(m_active));
    checkOutput("done", 32'(done), 32'(m_active && (m_age == HIGH_LEN)));
    checkOutput("pending", 32'(pending), 32'(m_pend));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (stretch_out === 1'b1 && prev_stretch !== 1'b1) rises++;
    if (done === 1'b1) dones++;
    prev_stretch = stretch_out;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    int density;
    // Reset held with pulse_in high must not start a pulse.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    idleCycles(6);
    checkOutput("no_start_after_reset", 32'(busy), 32'd0);

    // Single pulse.
    rises = 0;
    dones = 0;
    applyStimulus(1'b1, 1'b0);
    idleCycles(30);
    checkOutput("single_rises", 32'(rises), 32'd1);
    checkOutput("single_dones", 32'(dones), 32'd1);

    // Three requests queued during HIGH.
    rises = 0;
    dones = 0;
    applyStimulus(1'b1, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      idleCycles(2);
    end
    checkOutput("queued_three", 32'(pending), 32'd3);
    idleCycles(90);
    checkOutput("queued_rises", 32'(rises), 32'd4);
    checkOutput("queued_dones", 32'(dones), 32'd4);

    // Nine requests while busy saturate the queue.
    rises = 0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("sat_pending", 32'(pending), 32'(PEND_MAX));
    checkOutput("sat_overflow", 32'(overflow), 32'd1);
    idleCycles(170);
    checkOutput("sat_rises", 32'(rises), 32'd8);
    checkOutput("sat_overflow_sticky", 32'(overflow), 32'd1);

    // Request exactly at gap exit with two queued.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idleCycles(16);
    applyStimulus(1'b1, 1'b0);
    checkOutput("exit_pend2_pending", 32'(pending), 32'd2);
    checkOutput("exit_pend2_high", 32'(stretch_out), 32'd1);
    idleCycles(70);

    // Request exactly at gap exit with nothing queued.
    applyStimulus(1'b1, 1'b0);
    idleCycles(19);
    applyStimulus(1'b1, 1'b0);
    checkOutput("exit_pend0_pending", 32'(pending), 32'd0);
    checkOutput("exit_pend0_high", 32'(stretch_out), 32'd1);
    idleCycles(25);

    // Reset five cycles into HIGH with three queued and overflow still set.
    dones = 0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst_mid_stretch", 32'(stretch_out), 32'd0);
    checkOutput("rst_mid_pending", 32'(pending), 32'd0);
    checkOutput("rst_mid_overflow", 32'(overflow), 32'd0);
    idleCycles(25);
    checkOutput("rst_mid_no_done", 32'(dones), 32'd0);

    // Randomized traffic at several request densities with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 4)
        0:       density = 2;
        1:       density = 10;
        2:       density = 40;
        default: density = 90;
      endcase
      applyStimulus(($urandom_range(0, 99) < density) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
